sysarr_feeder: RTL

//  Upstream sequencer/collector for the n x n systolic matmul array. Buffers n operand

---
 rtl/sysarr_feeder_if.sv | 37 +++
 rtl/sysarr_feeder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sysarr_feeder_if.sv
// Bundle of the operand write port, run control, array drive/return and result
// signals between the operand loader, sysarr_feeder and the systolic array.
interface sysarr_feeder_if #(
  parameter int N = 31,
  parameter int n = 4
);
  localparam int W  = N + 1;
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  logic                 wr_en;
  logic                 wr_sel;
  logic [IW-1:0]        wr_idx;
  logic [W*n-1:0]       wr_data;
  logic                 start;
  logic                 busy;
  logic                 wr_err;
  logic [6:0]           flg;
  logic [W*n-1:0]       arr1;
  logic [W*n-1:0]       arr2;
  logic [W*n-1:0]       outrow;
  logic [W*(n-1)-1:0]   outcolumn;
  logic [W*n-1:0]       res_row;
  logic [W*(n-1)-1:0]   res_col;
  logic                 res_valid;

  // The feeder's view of the bus.
  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start, outrow, outcolumn,
    output busy, wr_err, flg, arr1, arr2, res_row, res_col, res_valid
  );

  // The loader/array side of the bus.
  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start, outrow, outcolumn,
    input  busy, wr_err, flg, arr1, arr2, res_row, res_col, res_valid
  );
endinterface

// File: rtl/sysarr_feeder.sv
// Operand buffer and step sequencer for the n x n systolic matmul array: feeds
// n A/B vector pairs, drains for DRAIN cycles, then captures the array result.
module sysarr_feeder #(
  parameter int N     = 31,
  parameter int n     = 4,
  parameter int DRAIN = 7
) (
  input logic           clk,
  input logic           rst_n,
  sysarr_feeder_if.slave bus
);
  localparam int W  = N + 1;
  localparam int IW = (n > 1) ? $clog2(n) : 1;
  localparam int VW = W * n;
  localparam int CW = W * (n - 1);
  localparam logic [6:0] FLG_HOLD = 7'(n);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_CAPTURE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_step;
  logic [7:0]    r_drain_cnt;

  logic [VW-1:0] r_abuf [n];
  logic [VW-1:0] r_bbuf [n];

  logic          r_busy;
  logic          r_wr_err;
  logic          r_res_valid;
  logic [6:0]    r_flg;
  logic [VW-1:0] r_arr1;
  logic [VW-1:0] r_arr2;
  logic [VW-1:0] r_res_row;
  logic [CW-1:0] r_res_col;

  logic [6:0]    w_flg_nxt;
  logic [VW-1:0] w_arr1_nxt;
  logic [VW-1:0] w_arr2_nxt;
  logic          w_idle;
  logic          w_start_acc;
  logic          w_wr_bad;
  logic          w_wr_ok;
  logic          w_feed_last;
  logic          w_drain_last;

  // The cycle carrying res_valid still reports busy, so it does not count as idle.
  assign w_idle       = (r_state == S_IDLE) && !r_busy;
  assign w_start_acc  = w_idle && bus.start;
  assign w_wr_bad     = bus.wr_en && (!w_idle || (int'(bus.wr_idx) >= n));
  assign w_wr_ok      = bus.wr_en && !w_wr_bad;
  assign w_feed_last  = (r_step == IW'(n - 1));
  assign w_drain_last = (r_drain_cnt == 8'(DRAIN - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start_acc)  w_state_nxt = S_FEED;
      S_FEED:    if (w_feed_last)  w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_drain_last) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Array drive for the cycle after this edge; outputs trail the state by one clock.
  always_comb begin
    w_flg_nxt  = FLG_HOLD;
    w_arr1_nxt = '0;
    w_arr2_nxt = '0;
    if (r_state == S_FEED) begin
      w_flg_nxt  = 7'(r_step);
      w_arr1_nxt = r_abuf[r_step];
      w_arr2_nxt = r_bbuf[r_step];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_step      <= (r_state == S_FEED && !w_feed_last) ? r_step + IW'(1) : '0;
      r_drain_cnt <= (r_state == S_DRAIN && !w_drain_last) ? r_drain_cnt + 8'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flg       <= FLG_HOLD;
      r_arr1      <= '0;
      r_arr2      <= '0;
      r_busy      <= 1'b0;
      r_wr_err    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_col   <= '0;
    end else begin
      r_flg       <= w_flg_nxt;
      r_arr1      <= w_arr1_nxt;
      r_arr2      <= w_arr2_nxt;
      r_busy      <= (r_state != S_IDLE) || w_start_acc;
      r_res_valid <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) begin
        r_res_row <= bus.outrow;
        r_res_col <= bus.outcolumn;
      end
      // A bad write in the same cycle as an accepted start still flags.
      if (w_start_acc) r_wr_err <= 1'b0;
      if (w_wr_bad)    r_wr_err <= 1'b1;
    end
  end

  // Operand storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (bus.wr_sel) r_bbuf[bus.wr_idx] <= bus.wr_data;
      else            r_abuf[bus.wr_idx] <= bus.wr_data;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.wr_err    = r_wr_err;
  assign bus.flg       = r_flg;
  assign bus.arr1      = r_arr1;
  assign bus.arr2      = r_arr2;
  assign bus.res_row   = r_res_row;
  assign bus.res_col   = r_res_col;
  assign bus.res_valid = r_res_valid;
endmodule
